// File: rtl/lattice_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lattice_pkg
//  Description : Shared types and constants for the D2Q9 neighbour address
//                generator: direction enumeration, unit offsets per direction
//                and edge-handling mode encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package lattice_pkg;

    localparam int NUM_DIRS = 9;

    // Direction order matches the BRAM read-port order downstream
    typedef enum logic [3:0] {
        D_C  = 4'd0,
        D_N  = 4'd1,
        D_NE = 4'd2,
        D_E  = 4'd3,
        D_SE = 4'd4,
        D_S  = 4'd5,
        D_SW = 4'd6,
        D_W  = 4'd7,
        D_NW = 4'd8
    } dir_e;

    // Unit x/y offsets per direction (N is y-1, E is x+1)
    localparam logic signed [1:0] DX [NUM_DIRS] = '{
        2'sb00, 2'sb00, 2'sb01, 2'sb01, 2'sb01, 2'sb00, 2'sb11, 2'sb11, 2'sb11
    };
    localparam logic signed [1:0] DY [NUM_DIRS] = '{
        2'sb00, 2'sb11, 2'sb11, 2'sb00, 2'sb01, 2'sb01, 2'sb01, 2'sb00, 2'sb11
    };

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_WALL     = 1'b1;

endpackage
`default_nettype wire

// File: rtl/lattice_neighbor.sv
`default_nettype none
// ============================================================================
//  Module      : lattice_neighbor
//  Description : Combinational single-direction neighbour address. Applies a
//                unit offset to the centre cell, wraps at the grid edges and,
//                in wall mode, replaces off-grid neighbours by the centre
//                address with the mask bit cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module lattice_neighbor
    import lattice_pkg::*;
#(
    parameter int HPIXELS   = 205,
    parameter int VPIXELS   = 154,
    parameter int HOR_SIZE  = $clog2(HPIXELS),
    parameter int VERT_SIZE = $clog2(VPIXELS),
    parameter int BRAM_SIZE = $clog2(HPIXELS * VPIXELS)
) (
    input  logic [HOR_SIZE-1:0]  i_x,
    input  logic [VERT_SIZE-1:0] i_y,
    input  logic signed [1:0]    i_dx,
    input  logic signed [1:0]    i_dy,
    input  logic                 i_mode,
    output logic [BRAM_SIZE-1:0] o_addr,
    output logic                 o_mask
);

    localparam logic [HOR_SIZE-1:0]  c_X_MAX = HOR_SIZE'(HPIXELS - 1);
    localparam logic [VERT_SIZE-1:0] c_Y_MAX = VERT_SIZE'(VPIXELS - 1);
    localparam logic [BRAM_SIZE-1:0] c_ROW   = BRAM_SIZE'(HPIXELS);

    logic [HOR_SIZE-1:0]  w_nx;
    logic [VERT_SIZE-1:0] w_ny;
    logic                 w_offx;
    logic                 w_offy;
    logic [BRAM_SIZE-1:0] w_centre;
    logic [BRAM_SIZE-1:0] w_nbr;

    // Wrapped neighbour coordinates, flagging any step that crossed an edge
    always_comb begin
        w_nx   = i_x;
        w_ny   = i_y;
        w_offx = 1'b0;
        w_offy = 1'b0;
        if (i_dx == 2'sb11) begin
            if (i_x == '0) begin
                w_nx   = c_X_MAX;
                w_offx = 1'b1;
            end else begin
                w_nx = i_x - HOR_SIZE'(1);
            end
        end else if (i_dx == 2'sb01) begin
            if (i_x == c_X_MAX) begin
                w_nx   = '0;
                w_offx = 1'b1;
            end else begin
                w_nx = i_x + HOR_SIZE'(1);
            end
        end
        if (i_dy == 2'sb11) begin
            if (i_y == '0) begin
                w_ny   = c_Y_MAX;
                w_offy = 1'b1;
            end else begin
                w_ny = i_y - VERT_SIZE'(1);
            end
        end else if (i_dy == 2'sb01) begin
            if (i_y == c_Y_MAX) begin
                w_ny   = '0;
                w_offy = 1'b1;
            end else begin
                w_ny = i_y + VERT_SIZE'(1);
            end
        end
    end

    // Linear addresses widened to the full BRAM width before multiply/add
    always_comb begin
        w_centre = c_ROW * BRAM_SIZE'(i_y) + BRAM_SIZE'(i_x);
        w_nbr    = c_ROW * BRAM_SIZE'(w_ny) + BRAM_SIZE'(w_nx);
        o_mask   = !((i_mode == MODE_WALL) && (w_offx || w_offy));
        o_addr   = o_mask ? w_nbr : w_centre;
    end

endmodule
`default_nettype wire

// File: rtl/lattice_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lattice_addr_gen
//  Description : Raster scanner over the lattice grid emitting the nine D2Q9
//                neighbour BRAM addresses per cell through a stallable
//                LATENCY-deep valid pipeline with valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module lattice_addr_gen
    import lattice_pkg::*;
#(
    parameter int HPIXELS   = 205,
    parameter int VPIXELS   = 154,
    parameter int LATENCY   = 3,
    parameter int HOR_SIZE  = $clog2(HPIXELS),
    parameter int VERT_SIZE = $clog2(VPIXELS),
    parameter int BRAM_SIZE = $clog2(HPIXELS * VPIXELS)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      start_in,
    input  logic                      wall_mode_in,
    output logic                      busy_out,
    output logic                      done_out,
    output logic [8:0][BRAM_SIZE-1:0] addr_out,
    output logic [8:0]                mask_out,
    output logic [HOR_SIZE-1:0]       hor_out,
    output logic [VERT_SIZE-1:0]      vert_out,
    output logic                      valid_out,
    input  logic                      ready_in
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [HOR_SIZE-1:0]  c_X_MAX = HOR_SIZE'(HPIXELS - 1);
    localparam logic [VERT_SIZE-1:0] c_Y_MAX = VERT_SIZE'(VPIXELS - 1);

    logic [1:0]           r_state;
    logic [HOR_SIZE-1:0]  r_x;
    logic [VERT_SIZE-1:0] r_y;
    logic                 r_mode;
    logic                 r_busy;
    logic                 r_done;

    logic [8:0][BRAM_SIZE-1:0] r_addr_q [LATENCY];
    logic [8:0]                r_mask_q [LATENCY];
    logic [HOR_SIZE-1:0]       r_hor_q  [LATENCY];
    logic [VERT_SIZE-1:0]      r_vert_q [LATENCY];
    logic [LATENCY-1:0]        r_vld;

    logic                      w_adv;
    logic                      w_start;
    logic                      w_issue;
    logic                      w_mode;
    logic                      w_last_cell;
    logic                      w_last_accept;
    logic [LATENCY-1:0]        w_upstream_vld;
    logic [8:0][BRAM_SIZE-1:0] w_addr;
    logic [8:0]                w_mask;

    // Cell (0,0) is issued on the start edge itself so the first word lands
    // exactly LATENCY cycles later; the mode input is used directly then
    // because the latched copy is not yet loaded.
    always_comb begin
        w_adv          = !(valid_out && !ready_in);
        w_start        = (r_state == S_IDLE) && start_in && w_adv;
        w_issue        = w_start || ((r_state == S_SCAN) && w_adv);
        w_mode         = (r_state == S_IDLE) ? wall_mode_in : r_mode;
        w_last_cell    = (r_x == c_X_MAX) && (r_y == c_Y_MAX);
        w_upstream_vld = r_vld;
        w_upstream_vld[LATENCY-1] = 1'b0;
        w_last_accept  = valid_out && ready_in && (w_upstream_vld == '0);
    end

    for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
        lattice_neighbor #(
            .HPIXELS  (HPIXELS),
            .VPIXELS  (VPIXELS),
            .HOR_SIZE (HOR_SIZE),
            .VERT_SIZE(VERT_SIZE),
            .BRAM_SIZE(BRAM_SIZE)
        ) u_nbr (
            .i_x   (r_x),
            .i_y   (r_y),
            .i_dx  (DX[d]),
            .i_dy  (DY[d]),
            .i_mode(w_mode),
            .o_addr(w_addr[d]),
            .o_mask(w_mask[d])
        );
    end

    // Scan FSM: raster counters advance per issued cell; done pulses for one
    // cycle in DRAIN before returning to IDLE
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_mode  <= MODE_PERIODIC;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_start) begin
                r_mode <= wall_mode_in;
                r_busy <= 1'b1;
            end
            if (w_issue) begin
                if (r_x == c_X_MAX) begin
                    r_x <= '0;
                    r_y <= (r_y == c_Y_MAX) ? '0 : r_y + VERT_SIZE'(1);
                end else begin
                    r_x <= r_x + HOR_SIZE'(1);
                end
                r_state <= w_last_cell ? S_DRAIN : S_SCAN;
            end
            if (r_state == S_DRAIN) begin
                if (r_done) begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end else if (w_last_accept) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    // Output pipeline shifts only on global advance so stalls hold every stage
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_addr_q[i] <= '0;
                r_mask_q[i] <= '0;
                r_hor_q[i]  <= '0;
                r_vert_q[i] <= '0;
            end
        end else if (w_adv) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                r_vld[i]    <= r_vld[i-1];
                r_addr_q[i] <= r_addr_q[i-1];
                r_mask_q[i] <= r_mask_q[i-1];
                r_hor_q[i]  <= r_hor_q[i-1];
                r_vert_q[i] <= r_vert_q[i-1];
            end
            r_vld[0]    <= w_issue;
            r_addr_q[0] <= w_addr;
            r_mask_q[0] <= w_mask;
            r_hor_q[0]  <= r_x;
            r_vert_q[0] <= r_y;
        end
    end

    assign valid_out = r_vld[LATENCY-1];
    assign addr_out  = r_addr_q[LATENCY-1];
    assign mask_out  = r_mask_q[LATENCY-1];
    assign hor_out   = r_hor_q[LATENCY-1];
    assign vert_out  = r_vert_q[LATENCY-1];
    assign busy_out  = r_busy;
    assign done_out  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lattice_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lattice_addr_gen
//  Description : Self-checking bench for lattice_addr_gen on a 4x3 grid with
//                an arithmetic neighbour model and randomized backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lattice_addr_gen;

    localparam int H   = 4;
    localparam int V   = 3;
    localparam int LAT = 3;
    localparam int N   = H * V;
    localparam int HW  = $clog2(H);
    localparam int VW  = $clog2(V);
    localparam int BW  = $clog2(H * V);

    localparam int TDX [9] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
    localparam int TDY [9] = '{0, -1, -1, 0, 1, 1, 1, 0, -1};

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b0;
    logic               start_in = 1'b0;
    logic               wall_mode_in = 1'b0;
    logic               ready_in = 1'b1;
    logic               busy_out;
    logic               done_out;
    logic [8:0][BW-1:0] addr_out;
    logic [8:0]         mask_out;
    logic [HW-1:0]      hor_out;
    logic [VW-1:0]      vert_out;
    logic               valid_out;

    int n_checks = 0;
    int n_fail   = 0;

    lattice_addr_gen #(
        .HPIXELS(H),
        .VPIXELS(V),
        .LATENCY(LAT)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start_in    (start_in),
        .wall_mode_in(wall_mode_in),
        .busy_out    (busy_out),
        .done_out    (done_out),
        .addr_out    (addr_out),
        .mask_out    (mask_out),
        .hor_out     (hor_out),
        .vert_out    (vert_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: neighbour coordinates by plain arithmetic, wrap via modulo
    function automatic void model(input int x, input int y, input bit wall,
                                  output logic [8:0][BW-1:0] a, output logic [8:0] m);
        for (int d = 0; d < 9; d++) begin
            int nx, ny;
            bit on;
            nx = x + TDX[d];
            ny = y + TDY[d];
            on = (nx >= 0) && (nx < H) && (ny >= 0) && (ny < V);
            if (!wall || on) begin
                a[d] = BW'(((ny + V) % V) * H + ((nx + H) % H));
                m[d] = 1'b1;
            end else begin
                a[d] = BW'(y * H + x);
                m[d] = 1'b0;
            end
        end
    endfunction

    task automatic run_scan(input bit mode, input int pct, input bit inject);
        int acc, first_k, x, y;
        bit fin, stalled;
        logic [8:0][BW-1:0] ea, s_addr;
        logic [8:0] em, s_mask;
        logic [HW+VW-1:0] s_hv;
        @(negedge clk_in);
        start_in = 1'b1;
        wall_mode_in = mode;
        ready_in = 1'b1;
        @(posedge clk_in);
        acc = 0; first_k = -1; fin = 0; stalled = 0;
        s_addr = '0; s_mask = '0; s_hv = '0;
        for (int k = 1; k <= 400 && !fin; k++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            wall_mode_in = mode;
            if (stalled) begin
                chk("stall_valid", valid_out, 1);
                chk("stall_addr", addr_out, s_addr);
                chk("stall_mask", mask_out, s_mask);
                chk("stall_hv", {hor_out, vert_out}, s_hv);
            end
            if (valid_out && first_k < 0) begin
                first_k = k;
                if (pct == 100) chk("first_latency", k, LAT);
            end
            chk("busy_during_scan", busy_out, 1);
            if (done_out) begin
                fin = 1;
                chk("done_word_count", acc, N);
                chk("done_no_valid", valid_out, 0);
                if (pct == 100) chk("done_latency", k, N + LAT);
                if (inject) start_in = 1'b1;
            end
            ready_in = ($urandom_range(99) < pct);
            if (inject && k == 5) begin
                start_in = 1'b1;
                wall_mode_in = !mode;
            end
            if (valid_out && ready_in) begin
                x = (acc % N) % H;
                y = (acc % N) / H;
                model(x, y, mode, ea, em);
                chk("word_hor", hor_out, x);
                chk("word_vert", vert_out, y);
                chk("word_mask", mask_out, em);
                chk("word_addr", addr_out, ea);
                if (!mode && acc == 0)     chk("lit_periodic_first", addr_out, 36'hB37451980);
                if (!mode && acc == N - 1) chk("lit_periodic_last", addr_out, 36'h6A230847B);
                if (mode && acc == 0) begin
                    chk("lit_wall_00_mask", mask_out, 9'h039);
                    chk("lit_wall_00_masked_addr",
                        {addr_out[1], addr_out[2], addr_out[6], addr_out[7], addr_out[8]}, 0);
                end
                if (mode && acc == H + 1) chk("lit_wall_11_mask", mask_out, 9'h1FF);
                acc++;
            end
            stalled = valid_out && !ready_in;
            s_addr = addr_out;
            s_mask = mask_out;
            s_hv = {hor_out, vert_out};
        end
        if (!fin) chk("scan_timeout", fin, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            wall_mode_in = mode;
            chk("post_done_low", done_out, 0);
            chk("post_busy_low", busy_out, 0);
            chk("post_valid_low", valid_out, 0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_valid", valid_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_addr", addr_out, 0);
        chk("rst_mask", mask_out, 0);
        chk("rst_hv", {hor_out, vert_out}, 0);
        rst_in = 1'b1;

        run_scan(1'b0, 100, 1'b0);
        run_scan(1'b1, 100, 1'b0);
        run_scan(1'b1, 50, 1'b1);
        run_scan(1'b0, 60, 1'b1);

        // Reset pulse in the middle of a scan
        @(negedge clk_in);
        start_in = 1'b1;
        wall_mode_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (5) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("midrst_valid", valid_out, 0);
        chk("midrst_busy", busy_out, 0);
        chk("midrst_done", done_out, 0);
        rst_in = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            chk("midrst_no_done", done_out, 0);
            chk("midrst_no_valid", valid_out, 0);
        end
        run_scan(1'b0, 100, 1'b0);

        for (int r = 0; r < 4; r++) begin
            run_scan(1'($urandom_range(1)), 30 + int'($urandom_range(60)), 1'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
